// File: rtl/hook_travel_control_pkg.sv
// Shared definitions for the hook travel controller and its step timer.
// Holds the FSM state encoding, path direction codes, phase encoding and the
// default screen limits and field widths.
package hook_travel_control_pkg;

   localparam int X_W_DEF      = 9;
   localparam int Y_W_DEF      = 8;
   localparam int Y_BOTTOM_DEF = 230;
   localparam int X_MIN_DEF    = 0;
   localparam int X_MAX_DEF    = 319;
   localparam int STEP_DEF     = 1;
   localparam int OBJ_W_DEF    = 5;
   localparam int WEIGHT_W_DEF = 2;

   typedef enum logic [1:0] {
      DIR_STRAIGHT = 2'b00,
      DIR_LEFT     = 2'b01,
      DIR_RIGHT    = 2'b10,
      DIR_ALT      = 2'b11   // behaves as straight
   } hook_dir_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRAW,
      S_WAIT,
      S_ERASE,
      S_CHECK_LD,
      S_CHECK_WAIT,
      S_DECIDE,
      S_MOVE,
      S_TRAIL,
      S_EXIT
   } hook_state_e;

   typedef enum logic {
      PH_EXTEND,
      PH_RETRACT
   } hook_phase_e;

endpackage

// File: rtl/hook_travel_control_step_timer.sv
// Step timer: counts tick pulses up to a loadable target.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - holds the count at zero (asserted whenever the owner is not waiting)
//   tick        - step pulse from the shared time counter
//   target      - number of ticks to wait for (>= 1)
//   reached     - count has reached target
module hook_travel_control_step_timer #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             tick,
   input  logic [CNT_W-1:0] target,
   output logic             reached
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (tick && !reached) begin
         count <= count + CNT_W'(1);
      end
   end

   assign reached = (count == target);

endmodule

// File: rtl/hook_travel_control.sv
// Hook travel controller: extends the hook from its origin along a straight or
// diagonal path, probing for an object at every step, then retracts it to the
// origin at a speed scaled by the caught object's weight. A trail pixel is
// drawn at each position left behind while extending and erased while
// retracting.
// Ports:
//   start/origin_x/origin_y/dir - cycle request and path, latched in IDLE
//   tick/tick_en                - shared step pulse and its enable
//   draw_req/erase/draw_done    - hook sprite draw or erase at (hook_x, hook_y)
//   trail_*                     - one-cycle trail pixel write at the old position
//   check_ld/check_en/check_*   - object probe under the hook
//   done/caught/caught_obj/hit_limit - cycle result, valid until the next start
//   state_dbg                   - current FSM state
// Handshakes: draw_req stays high until draw_done is seen in DRAW/ERASE;
// check_en stays high until check_done, whose check_obj/check_weight are
// captured in that same cycle; done stays high until start drops.
module hook_travel_control
   import hook_travel_control_pkg::*;
#(
   parameter int X_W      = X_W_DEF,
   parameter int Y_W      = Y_W_DEF,
   parameter int Y_BOTTOM = Y_BOTTOM_DEF,
   parameter int X_MIN    = X_MIN_DEF,
   parameter int X_MAX    = X_MAX_DEF,
   parameter int STEP     = STEP_DEF,
   parameter int OBJ_W    = OBJ_W_DEF,
   parameter int WEIGHT_W = WEIGHT_W_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [X_W-1:0]      origin_x,
   input  logic [Y_W-1:0]      origin_y,
   input  logic [1:0]          dir,
   input  logic                tick,
   output logic                tick_en,
   input  logic                draw_done,
   output logic                draw_req,
   output logic                erase,
   output logic [X_W-1:0]      hook_x,
   output logic [Y_W-1:0]      hook_y,
   output logic                trail_req,
   output logic                trail_erase,
   output logic [X_W-1:0]      trail_x,
   output logic [Y_W-1:0]      trail_y,
   output logic                check_ld,
   output logic                check_en,
   input  logic                check_done,
   input  logic [OBJ_W-1:0]    check_obj,
   input  logic [WEIGHT_W-1:0] check_weight,
   output logic                done,
   output logic                caught,
   output logic [OBJ_W-1:0]    caught_obj,
   output logic                hit_limit,
   output hook_state_e         state_dbg
);

   localparam int CNT_W = WEIGHT_W + 1;
   localparam logic [X_W-1:0] STEP_X  = STEP[X_W-1:0];
   localparam logic [Y_W-1:0] STEP_Y  = STEP[Y_W-1:0];
   localparam logic [X_W:0]   X_MAX_L = X_MAX[X_W:0];
   localparam logic [X_W:0]   X_MIN_L = X_MIN[X_W:0];
   localparam logic [Y_W:0]   Y_BOT_L = Y_BOTTOM[Y_W:0];

   hook_state_e          state, state_next;
   hook_phase_e          phase;
   hook_dir_e            dir_q;
   logic [X_W-1:0]       org_x;
   logic [Y_W-1:0]       org_y;
   logic [WEIGHT_W-1:0]  weight_q;
   logic [OBJ_W-1:0]     obj_res;
   logic [WEIGHT_W-1:0]  wt_res;
   logic                 at_home;
   logic [X_W-1:0]       x_fwd, x_back;
   logic                 limit_next, home_next, reached;
   logic [CNT_W-1:0]     tick_target;

   // Bounds are evaluated one bit wider so the next-step position cannot wrap.
   assign limit_next =
      (({1'b0, hook_y} + {1'b0, STEP_Y}) > Y_BOT_L) ||
      ((dir_q == DIR_RIGHT) && (({1'b0, hook_x} + {1'b0, STEP_X}) > X_MAX_L)) ||
      ((dir_q == DIR_LEFT)  && ({1'b0, hook_x} < (X_MIN_L + {1'b0, STEP_X})));

   // Equivalent to y-STEP <= origin_y without unsigned underflow.
   assign home_next = ({1'b0, hook_y} <= ({1'b0, org_y} + {1'b0, STEP_Y}));

   always_comb begin
      x_fwd  = hook_x;
      x_back = hook_x;
      case (dir_q)
         DIR_LEFT: begin
            x_fwd  = hook_x - STEP_X;
            x_back = hook_x + STEP_X;
         end
         DIR_RIGHT: begin
            x_fwd  = hook_x + STEP_X;
            x_back = hook_x - STEP_X;
         end
         default: ;
      endcase
   end

   assign tick_target = (phase == PH_EXTEND) ? CNT_W'(1)
                                             : ({1'b0, weight_q} + CNT_W'(1));

   hook_travel_control_step_timer #(.CNT_W(CNT_W)) u_step_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state != S_WAIT),
      .tick    (tick),
      .target  (tick_target),
      .reached (reached)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next  = state;
      tick_en     = 1'b0;
      draw_req    = 1'b0;
      erase       = 1'b0;
      trail_req   = 1'b0;
      trail_erase = 1'b0;
      check_ld    = 1'b0;
      check_en    = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE:       if (start) state_next = S_DRAW;
         S_DRAW: begin
            draw_req = 1'b1;
            if (draw_done) state_next = S_WAIT;
         end
         S_WAIT: begin
            tick_en = 1'b1;
            if (reached) state_next = S_ERASE;
         end
         S_ERASE: begin
            draw_req = 1'b1;
            erase    = 1'b1;
            if (draw_done) state_next = (phase == PH_EXTEND) ? S_CHECK_LD : S_MOVE;
         end
         S_CHECK_LD: begin
            check_ld   = 1'b1;
            state_next = S_CHECK_WAIT;
         end
         S_CHECK_WAIT: begin
            check_en = 1'b1;
            if (check_done) state_next = S_DECIDE;
         end
         S_DECIDE:     state_next = S_MOVE;
         S_MOVE:       state_next = S_TRAIL;
         S_TRAIL: begin
            trail_req   = 1'b1;
            trail_erase = (phase == PH_RETRACT);
            state_next  = at_home ? S_EXIT : S_DRAW;
         end
         S_EXIT: begin
            done = 1'b1;
            if (!start) state_next = S_IDLE;
         end
         default:      state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hook_x     <= '0;
         hook_y     <= '0;
         org_x      <= '0;
         org_y      <= '0;
         dir_q      <= DIR_STRAIGHT;
         phase      <= PH_EXTEND;
         weight_q   <= '0;
         obj_res    <= '0;
         wt_res     <= '0;
         at_home    <= 1'b0;
         trail_x    <= '0;
         trail_y    <= '0;
         caught     <= 1'b0;
         caught_obj <= '0;
         hit_limit  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               hook_x     <= origin_x;
               hook_y     <= origin_y;
               org_x      <= origin_x;
               org_y      <= origin_y;
               dir_q      <= (dir == DIR_ALT) ? DIR_STRAIGHT : hook_dir_e'(dir);
               phase      <= PH_EXTEND;
               weight_q   <= '0;
               at_home    <= 1'b0;
               caught     <= 1'b0;
               caught_obj <= '0;
               hit_limit  <= 1'b0;
            end
            S_CHECK_WAIT: if (check_done) begin
               obj_res <= check_obj;
               wt_res  <= check_weight;
            end
            S_DECIDE: begin
               // An object beats a boundary hit in the same step.
               if (obj_res != '0) begin
                  caught     <= 1'b1;
                  caught_obj <= obj_res;
                  weight_q   <= wt_res;
                  phase      <= PH_RETRACT;
               end else if (limit_next) begin
                  hit_limit <= 1'b1;
                  phase     <= PH_RETRACT;
               end
            end
            S_MOVE: begin
               trail_x <= hook_x;
               trail_y <= hook_y;
               if (phase == PH_EXTEND) begin
                  hook_x <= x_fwd;
                  hook_y <= hook_y + STEP_Y;
               end else if (home_next) begin
                  hook_x  <= org_x;
                  hook_y  <= org_y;
                  at_home <= 1'b1;
               end else begin
                  hook_x <= x_back;
                  hook_y <= hook_y - STEP_Y;
               end
            end
            default: ;
         endcase
      end
   end

   assign state_dbg = state;

endmodule

// File: tb/tb_hook_travel_control.sv
// Bench for hook_travel_control: drives hook cycles over a field holding at
// most one object and checks trail writes, per-step tick waits and the cycle
// result against a path model computed from the hook movement rules.
module tb_hook_travel_control;
   import hook_travel_control_pkg::*;

   localparam int X_W      = 9;
   localparam int Y_W      = 8;
   localparam int OBJ_W    = 5;
   localparam int WEIGHT_W = 2;
   localparam int YB       = 30;
   localparam int XMIN     = 0;
   localparam int XMAX     = 319;
   localparam int STEP     = 1;
   localparam int TW       = X_W + Y_W + 1;

   logic                clk = 1'b0;
   logic                reset, start, tick, tick_en, draw_done, draw_req, erase;
   logic [X_W-1:0]      origin_x, hook_x, trail_x;
   logic [Y_W-1:0]      origin_y, hook_y, trail_y;
   logic [1:0]          dir;
   logic                trail_req, trail_erase, check_ld, check_en, check_done;
   logic [OBJ_W-1:0]    check_obj, caught_obj;
   logic [WEIGHT_W-1:0] check_weight;
   logic                done, caught, hit_limit;
   hook_state_e         state_dbg;

   int checks = 0;
   int errors = 0;
   logic [TW-1:0] exp_q[$];
   int            exp_tick_q[$];
   bit            sb_on = 1'b0;
   bit            fast = 1'b0;
   logic [X_W-1:0]      obj_x = '0;
   logic [Y_W-1:0]      obj_y = '0;
   logic [OBJ_W-1:0]    obj_id = '0;
   logic [WEIGHT_W-1:0] obj_wt = '0;

   hook_travel_control #(.Y_BOTTOM(YB)) dut (
      .clk(clk), .reset(reset), .start(start), .origin_x(origin_x), .origin_y(origin_y),
      .dir(dir), .tick(tick), .tick_en(tick_en), .draw_done(draw_done), .draw_req(draw_req),
      .erase(erase), .hook_x(hook_x), .hook_y(hook_y), .trail_req(trail_req),
      .trail_erase(trail_erase), .trail_x(trail_x), .trail_y(trail_y), .check_ld(check_ld),
      .check_en(check_en), .check_done(check_done), .check_obj(check_obj),
      .check_weight(check_weight), .done(done), .caught(caught), .caught_obj(caught_obj),
      .hit_limit(hit_limit), .state_dbg(state_dbg)
   );

   // Clock / reset-independent stimulus sources
   always #5 clk = ~clk;

   // Ticks change just after the rising edge and never on two cycles in a row.
   initial begin
      tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tick = !tick && ($urandom_range(0, 2) == 0);
      end
   end

   // Sprite draw responder: one-cycle draw_done after a random delay.
   initial begin
      int dly;
      dly = -1;
      draw_done = 1'b0;
      forever begin
         @(negedge clk);
         draw_done = 1'b0;
         if (reset || !draw_req) dly = -1;
         else begin
            if (dly < 0) dly = fast ? 0 : $urandom_range(0, 3);
            if (dly == 0) begin
               draw_done = 1'b1;
               dly = -1;
            end else dly--;
         end
      end
   end

   // Object check responder: looks up the probed position in the field.
   initial begin
      int dly;
      logic [X_W-1:0] qx;
      logic [Y_W-1:0] qy;
      dly = -1; qx = '0; qy = '0;
      check_done = 1'b0; check_obj = '0; check_weight = '0;
      forever begin
         @(negedge clk);
         check_done = 1'b0;
         if (reset) dly = -1;
         else if (check_ld) begin
            qx = hook_x;
            qy = hook_y;
            dly = fast ? 0 : $urandom_range(0, 3);
         end else if (check_en && dly >= 0) begin
            if (dly == 0) begin
               check_done = 1'b1;
               if (qx == obj_x && qy == obj_y) begin
                  check_obj = obj_id;
                  check_weight = obj_wt;
               end else begin
                  check_obj = '0;
                  check_weight = WEIGHT_W'($urandom_range(0, 3));
               end
               dly = -1;
            end else dly--;
         end
      end
   end

   // Scoreboard: trail pixel writes in order.
   initial begin
      logic [TW-1:0] e;
      forever begin
         @(negedge clk);
         if (!reset && sb_on && trail_req) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL trail_extra got erase=%0b x=%0d y=%0d want none", trail_erase, trail_x, trail_y);
            end else begin
               e = exp_q.pop_front();
               if ({trail_erase, trail_x, trail_y} !== e) begin
                  errors++;
                  $display("FAIL trail got erase=%0b x=%0d y=%0d want erase=%0b x=%0d y=%0d",
                           trail_erase, trail_x, trail_y, e[TW-1], e[TW-2 -: X_W], e[Y_W-1:0]);
               end
            end
         end
      end
   end

   // Scoreboard: ticks consumed by each wait window.
   initial begin
      int cnt, e;
      bit prev_en;
      cnt = 0; prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cnt = 0;
            prev_en = 1'b0;
         end else begin
            if (tick_en) begin
               if (tick) cnt++;
            end else if (prev_en) begin
               if (sb_on) begin
                  checks++;
                  if (exp_tick_q.size() == 0) begin
                     errors++;
                     $display("FAIL wait_extra got %0d ticks want no wait", cnt);
                  end else begin
                     e = exp_tick_q.pop_front();
                     if (cnt != e) begin
                        errors++;
                        $display("FAIL wait_ticks got %0d want %0d", cnt, e);
                     end
                  end
               end
               cnt = 0;
            end
            prev_en = tick_en;
         end
      end
   end

   // Runs one full hook cycle and checks the result against the path model.
   task automatic run_cycle(input int ox, input int oy, input logic [1:0] d,
                            input int ox_obj, input int oy_obj, input int id, input int wt,
                            input bit toggle, input string name);
      int dx, x, y, w, cyc;
      bit e_caught, e_hit;
      int e_obj;
      dx = (d == 2'b01) ? -1 : (d == 2'b10) ? 1 : 0;
      obj_x = X_W'(ox_obj); obj_y = Y_W'(oy_obj);
      obj_id = OBJ_W'(id); obj_wt = WEIGHT_W'(wt);
      exp_q.delete();
      exp_tick_q.delete();
      x = ox; y = oy; w = 0; e_caught = 0; e_hit = 0; e_obj = 0;
      forever begin
         exp_tick_q.push_back(1);
         if (id != 0 && x == ox_obj && y == oy_obj) begin
            e_caught = 1; e_obj = id; w = wt;
            break;
         end
         if (y + STEP > YB || x + dx * STEP > XMAX || x + dx * STEP < XMIN) begin
            e_hit = 1;
            break;
         end
         exp_q.push_back({1'b0, x[X_W-1:0], y[Y_W-1:0]});
         x = x + dx * STEP;
         y = y + STEP;
      end
      forever begin
         exp_q.push_back({1'b1, x[X_W-1:0], y[Y_W-1:0]});
         if (y - STEP <= oy) break;
         x = x - dx * STEP;
         y = y - STEP;
         exp_tick_q.push_back(w + 1);
      end
      sb_on = 1'b1;
      @(negedge clk);
      origin_x = X_W'(ox); origin_y = Y_W'(oy); dir = d; start = 1'b1;
      cyc = 0;
      while (!done && cyc < 8000) begin
         @(negedge clk);
         cyc++;
         if (toggle) start = (cyc < 40) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s done_timeout got done=0 want 1 within 8000 cycles", name);
         sb_on = 1'b0;
         reset = 1'b1; start = 1'b0;
         repeat (2) @(negedge clk);
         reset = 1'b0;
         return;
      end
      start = 1'b1;
      checks++;
      if (caught !== e_caught) begin
         errors++; $display("FAIL %s caught got %0b want %0b", name, caught, e_caught);
      end
      checks++;
      if (caught_obj !== OBJ_W'(e_obj)) begin
         errors++; $display("FAIL %s caught_obj got %0d want %0d", name, caught_obj, e_obj);
      end
      checks++;
      if (hit_limit !== e_hit) begin
         errors++; $display("FAIL %s hit_limit got %0b want %0b", name, hit_limit, e_hit);
      end
      checks++;
      if (hook_x !== X_W'(ox) || hook_y !== Y_W'(oy)) begin
         errors++; $display("FAIL %s home got (%0d,%0d) want (%0d,%0d)", name, hook_x, hook_y, ox, oy);
      end
      checks++;
      if (exp_q.size() != 0 || exp_tick_q.size() != 0) begin
         errors++;
         $display("FAIL %s leftover got trail=%0d waits=%0d want 0 0", name, exp_q.size(), exp_tick_q.size());
      end
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b1) begin
         errors++; $display("FAIL %s done_hold got %0b want 1", name, done);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (done !== 1'b0 || state_dbg !== S_IDLE || caught !== e_caught || hit_limit !== e_hit) begin
         errors++;
         $display("FAIL %s after_exit got done=%0b state=%0d caught=%0b hit=%0b want 0 %0d %0b %0b",
                  name, done, state_dbg, caught, hit_limit, S_IDLE, e_caught, e_hit);
      end
      sb_on = 1'b0;
   endtask

   task automatic check_all_zero(input string name);
      checks++;
      if ({tick_en, draw_req, erase, hook_x, hook_y, trail_req, trail_erase, trail_x, trail_y,
           check_ld, check_en, done, caught, caught_obj, hit_limit} !== '0 || state_dbg !== S_IDLE) begin
         errors++;
         $display("FAIL %s outputs got %h state=%0d want 0 state=%0d", name,
                  {tick_en, draw_req, erase, hook_x, hook_y, trail_req, trail_erase, trail_x, trail_y,
                   check_ld, check_en, done, caught, caught_obj, hit_limit}, state_dbg, S_IDLE);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; origin_x = '0; origin_y = '0; dir = 2'b00;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_straight_empty();
      fast = 1'b1;
      run_cycle(160, 20, 2'b00, 0, 0, 0, 0, 1'b0, "straight_empty");
      fast = 1'b0;
   endtask

   task automatic test_right_catch();
      run_cycle(160, 20, 2'b10, 165, 25, 5, 2, 1'b0, "right_catch");
   endtask

   task automatic test_left_limit();
      run_cycle(3, 20, 2'b01, 0, 0, 0, 0, 1'b0, "left_limit");
   endtask

   task automatic test_obj_at_bottom();
      run_cycle(100, 20, 2'b00, 100, YB, 7, 3, 1'b0, "obj_at_bottom");
      run_cycle(50, YB, 2'b11, 0, 0, 0, 0, 1'b0, "origin_at_bottom");
      run_cycle(XMAX, 10, 2'b10, 0, 0, 0, 0, 1'b0, "right_edge");
   endtask

   task automatic test_reset_mid();
      int cyc;
      sb_on = 1'b0;
      obj_id = '0;
      @(negedge clk);
      origin_x = 9'd160; origin_y = 8'd20; dir = 2'b10; start = 1'b1;
      cyc = 0;
      while (!check_en && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (!check_en) begin
         errors++; $display("FAIL reset_mid reach_check got check_en=0 want 1");
      end
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("reset_mid");
      start = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset_mid_idle");
      run_cycle(40, 5, 2'b01, 36, 9, 12, 1, 1'b0, "after_reset_mid");
   endtask

   task automatic test_start_toggle();
      run_cycle(200, 12, 2'b10, 0, 0, 0, 0, 1'b1, "start_toggle");
   endtask

   task automatic test_random();
      int ox, oy, dx, k, id, ob_x, ob_y;
      logic [1:0] d;
      for (int i = 0; i < 12; i++) begin
         ox = $urandom_range(XMIN, XMAX);
         oy = $urandom_range(0, YB);
         d = 2'($urandom_range(0, 3));
         dx = (d == 2'b01) ? -1 : (d == 2'b10) ? 1 : 0;
         k = $urandom_range(0, YB - oy + 1);
         ob_x = ox + dx * k;
         ob_y = oy + k;
         id = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 31) : 0;
         if (ob_x < XMIN || ob_x > XMAX) begin
            ob_x = 0;
            id = 0;
         end
         run_cycle(ox, oy, d, ob_x, ob_y, id, $urandom_range(0, 3), 1'b0, "random");
      end
   endtask

   initial begin
      test_reset();
      test_straight_empty();
      test_right_catch();
      test_left_limit();
      test_obj_at_bottom();
      test_reset_mid();
      test_start_toggle();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
